// File: rtl/alu_pipe_param.sv
// rtl/alu_pipe_param.sv - WIDTH-bit ALU with a STAGES-deep elastic valid/ready pipeline and drop counter
// Optional shifter/rotator for opcodes 10-13 is enabled by defining ALU_SHIFT_ROT_EN.
module alu_pipe_param #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       ctl,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] alu,
  output logic             carry,
  output logic             zero,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int DW = WIDTH + 2;
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [WIDTH-1:0]  res_alu;
  logic              res_carry;
  logic              res_zero;
  logic              op_ok;
  logic [WIDTH:0]    ext;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] adv;
  logic              hole;
  logic [DW-1:0]     data_q [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, load0, drop_hit;

  always_comb begin
    op_ok     = 1'b1;
    res_alu   = '0;
    res_carry = 1'b0;
    ext       = '0;
    case (ctl)
      4'd0: res_alu = b;
      4'd1: res_alu = b + ONE_W;
      4'd2: res_alu = b - ONE_W;
      4'd3: begin
        ext       = {1'b0, a} + {1'b0, b};
        res_alu   = ext[WIDTH-1:0];
        res_carry = ext[WIDTH];
      end
      4'd4: begin
        ext       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res_alu   = ext[WIDTH-1:0];
        res_carry = ext[WIDTH];
      end
      // Bit WIDTH of the extended difference is the borrow (a < b + cin)
      4'd5: begin
        ext       = {1'b0, a} - {1'b0, b};
        res_alu   = ext[WIDTH-1:0];
        res_carry = ext[WIDTH];
      end
      4'd6: begin
        ext       = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        res_alu   = ext[WIDTH-1:0];
        res_carry = ext[WIDTH];
      end
      4'd7: res_alu = a & b;
      4'd8: res_alu = a | b;
      4'd9: res_alu = a ^ b;
`ifdef ALU_SHIFT_ROT_EN
      4'd10: res_alu = {a[WIDTH-2:0], 1'b0};
      4'd11: res_alu = {1'b0, a[WIDTH-1:1]};
      4'd12: res_alu = {a[WIDTH-2:0], a[WIDTH-1]};
      4'd13: res_alu = {a[0], a[WIDTH-1:1]};
`endif
      default: op_ok = 1'b0;
    endcase
    res_zero = ~|res_alu;
  end

  // A stage moves on when the output drains or any later stage has a hole to fill
  always_comb begin
    adv  = '0;
    hole = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      hole = ready_in;
      for (int j = i + 1; j < STAGES; j++) begin
        if (!v_q[j]) hole = 1'b1;
      end
      adv[i] = v_q[i] & hole;
    end
  end

  assign ready_out = !v_q[0] || adv[0];
  assign accept    = valid_in && ready_out;
  assign load0     = accept && op_ok;
  assign drop_hit  = accept && !op_ok;

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < STAGES; i++) begin
      if (adv[i]) v_d[i] = 1'b0;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (adv[i-1]) v_d[i] = 1'b1;
    end
    if (load0) v_d[0] = 1'b1;
    cnt_d = (drop_hit && (cnt_q != '1)) ? cnt_q + ONE_C : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      if (load0) data_q[0] <= {res_alu, res_carry, res_zero};
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_out              = v_q[STAGES-1];
  assign {alu, carry, zero}     = data_q[STAGES-1];
  assign drop_cnt               = cnt_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb/tb_alu_pipe_param.sv - self-checking bench for alu_pipe_param (WIDTH=8, STAGES=2, CNT_W=8)
// Expectations for opcodes 10-13 follow ALU_SHIFT_ROT_EN when defined.
module tb_alu_pipe_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a, b;
  logic       cin;
  logic [3:0] ctl;
  logic       valid_in, ready_in;
  logic       ready_out, valid_out, carry, zero;
  logic [7:0] alu, drop_cnt;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         exp_drop = 0;
  bit         acc;
  logic       obs_v;
  logic [9:0] obs_res;

  always #5 clk = ~clk;

  alu_pipe_param #(.WIDTH(8), .STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin), .ctl(ctl),
    .valid_in(valid_in), .ready_out(ready_out), .valid_out(valid_out),
    .ready_in(ready_in), .alu(alu), .carry(carry), .zero(zero), .drop_cnt(drop_cnt)
  );

  // Reference: {valid_opcode, alu[7:0], carry, zero} from plain integer arithmetic
  function automatic logic [10:0] ref_op(input int c, input int x, input int y, input int ci);
    int r; bit cy; bit ok; logic [7:0] rb;
    r = 0; cy = 0; ok = 1;
    case (c)
      0: r = y;
      1: r = y + 1;
      2: r = y - 1;
      3: begin r = x + y; cy = (r > 255); end
      4: begin r = x + y + ci; cy = (r > 255); end
      5: begin r = x - y; cy = (x < y); end
      6: begin r = x - y - ci; cy = (x < y + ci); end
      7: r = x & y;
      8: r = x | y;
      9: r = x ^ y;
`ifdef ALU_SHIFT_ROT_EN
      10: r = x * 2;
      11: r = x / 2;
      12: r = (x * 2) % 256 + x / 128;
      13: r = x / 2 + (x % 2) * 128;
`endif
      default: ok = 0;
    endcase
    r  = ((r % 256) + 256) % 256;
    rb = r[7:0];
    return {ok, rb, cy, (rb == 8'd0)};
  endfunction

  task automatic tick();
    logic [10:0] r;
    @(negedge clk);
    acc     = valid_in && ready_out && reset;
    obs_v   = valid_out;
    obs_res = {alu, carry, zero};
    if (!reset) begin
      exp_q.delete();
      exp_drop = 0;
    end else begin
      if (acc) begin
        r = ref_op(ctl, a, b, cin);
        if (r[10]) exp_q.push_back(r[9:0]);
        else if (exp_drop < 255) exp_drop++;
      end
      if (valid_out && ready_in) got_q.push_back({alu, carry, zero});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y, input logic ci);
    ctl = c; a = x; b = y; cin = ci; valid_in = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (acc) break;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: ctl=%0d not accepted within 50 cycles", c);
    end
    valid_in = 1'b0;
  endtask

  task automatic drain(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    valid_in = 1'b0; ready_in = 1'b1;
    do_reset();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (alu !== 8'h00) begin errors++; $display("FAIL reset_alu: got %h want 00", alu); end
    checks++; if ({carry, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {carry, zero}); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop: got %h want 00", drop_cnt); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_out); end
  endtask

  task automatic test_latency();
    ready_in = 1'b1;
    send(4'd3, 8'hF0, 8'h20, 1'b0);
    tick();
    checks++; if (obs_v !== 1'b0) begin errors++; $display("FAIL lat_early: valid_out got %b want 0", obs_v); end
    tick();
    checks++; if (obs_v !== 1'b1) begin errors++; $display("FAIL lat_valid: valid_out got %b want 1", obs_v); end
    checks++; if (obs_res !== 10'h042) begin errors++; $display("FAIL lat_add: got %h want 042", obs_res); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_vectors();
    logic [3:0] vc[4];
    logic [7:0] va[4], vb[4];
    logic       vci[4];
    logic [9:0] vexp[4];
    vc = '{4'd4, 4'd5, 4'd6, 4'd2};
    va = '{8'hFF, 8'h05, 8'h05, 8'h00};
    vb = '{8'h00, 8'h05, 8'h05, 8'h00};
    vci = '{1'b1, 1'b0, 1'b1, 1'b0};
    vexp = '{10'h003, 10'h001, 10'h3FE, 10'h3FC};
    got_q.delete(); exp_q.delete();
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) send(vc[i], va[i], vb[i], vci[i]);
    drain(4);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL vec_count: got %0d want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== vexp[i]) begin errors++; $display("FAIL vec_%0d: got %h want %h", i, got_q[i], vexp[i]); end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    got_q.delete(); exp_q.delete();
    ready_in = 1'b0;
    ctl = 4'd1; a = 8'h00; b = 8'h00; cin = 1'b0; valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (acc) begin idx++; b = 8'(idx); end
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", idx); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", ready_out); end
    checks++; if ({valid_out, alu} !== 9'h101) begin errors++; $display("FAIL bp_frozen: got %h want 101", {valid_out, alu}); end
    ready_in = 1'b1;
    for (int k = 0; k < 20 && idx < 6; k++) begin
      tick();
      if (acc) begin idx++; b = 8'(idx); end
    end
    drain(4);
    checks++;
    if (got_q.size() != 6) begin
      errors++; $display("FAIL bp_count: got %0d want 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[i] !== 10'((i + 1) * 4)) begin
          errors++; $display("FAIL bp_order_%0d: got %h want %h", i, got_q[i], 10'((i + 1) * 4));
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_drop();
    do_reset();
    ready_in = 1'b1;
    send(4'd14, 8'h12, 8'h34, 1'b0);
    send(4'd15, 8'h56, 8'h78, 1'b0);
    send(4'd7, 8'h0F, 8'h3C, 1'b0);
    drain(4);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL drop_count_out: got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 10'h030) begin errors++; $display("FAIL drop_and: got %h want 030", got_q[0]); end
    end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_cnt2: got %h want 02", drop_cnt); end
    for (int k = 0; k < 300; k++) send(4'(14 + (k % 2)), 8'(k), 8'(k), 1'b0);
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL drop_sat: got %h want FF", drop_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_shiftrot();
    do_reset();
    ready_in = 1'b1;
    send(4'd12, 8'h81, 8'h00, 1'b0);
    drain(4);
`ifdef ALU_SHIFT_ROT_EN
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL rotl_count: got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 10'h00C) begin errors++; $display("FAIL rotl_val: got %h want 00C", got_q[0]); end
    end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rotl_drop: got %h want 00", drop_cnt); end
`else
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rotl_count: got %0d want 0", got_q.size()); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL rotl_drop: got %h want 01", drop_cnt); end
`endif
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      ctl = 4'($urandom_range(0, 15));
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      tick();
    end
    valid_in = 1'b0; ready_in = 1'b1;
    drain(8);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL rand_drop: got %h want %h", drop_cnt, 8'(exp_drop)); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    ready_in = 1'b1;
    send(4'd15, 8'h00, 8'h00, 1'b0);
    ready_in = 1'b0;
    send(4'd3, 8'h01, 8'h01, 1'b0);
    send(4'd3, 8'h02, 8'h02, 1'b0);
    checks++; if ({valid_out, drop_cnt} !== 9'h101) begin errors++; $display("FAIL rif_pre: got %h want 101", {valid_out, drop_cnt}); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rif_valid: got %b want 0", valid_out); end
    checks++; if ({alu, carry, zero} !== 10'h000) begin errors++; $display("FAIL rif_out: got %h want 000", {alu, carry, zero}); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rif_drop: got %h want 00", drop_cnt); end
    got_q.delete();
    ready_in = 1'b1;
    drain(5);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rif_emit: got %0d want 0", got_q.size()); end
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    a = '0; b = '0; cin = 1'b0; ctl = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_drop();
    test_shiftrot();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
